// File: rtl/led_matrix_scan_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_matrix_scan_gen
//  Description : Row-scanned LED matrix driver with per-pixel grey-scale PWM,
//                CH colour channels, an internal framebuffer written through a
//                valid/ready port, anti-ghost blanking, a bulk clear sweep and
//                global invert.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_matrix_scan_gen #(
    parameter  int ROWS      = 8,
    parameter  int COLS      = 8,
    parameter  int CH        = 2,
    parameter  int GRAY_BITS = 4,
    parameter  int PRESCALE  = 1,
    parameter  int BLANK_CYC = 4,
    localparam int c_rw      = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int c_cw      = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int c_dw      = CH * GRAY_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              invert,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [c_rw-1:0]   wr_row,
    input  logic [c_cw-1:0]   wr_col,
    input  logic [c_dw-1:0]   wr_data,
    output logic [ROWS-1:0]   row_n,
    output logic [CH*COLS-1:0] col,
    output logic [c_rw-1:0]   scan_row,
    output logic              frame_start
);

    localparam int c_pw = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_bw = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

    localparam logic [GRAY_BITS-1:0] c_pcnt_max  = '1;
    localparam logic [c_pw-1:0]      c_presc_max = c_pw'(PRESCALE - 1);
    localparam logic [c_bw-1:0]      c_blank_max = c_bw'(BLANK_CYC - 1);
    localparam logic [c_rw-1:0]      c_row_max   = c_rw'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_BLANK  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_CLEAR  = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_rw-1:0]       r_scan_row;
    logic [c_bw-1:0]       r_bcnt;
    logic [c_rw-1:0]       r_ccnt;
    logic [GRAY_BITS-1:0]  r_pcnt;
    logic [c_pw-1:0]       r_presc;

    logic [c_dw-1:0]       r_fb     [ROWS][COLS];
    logic [c_dw-1:0]       r_shadow [COLS];

    logic                  w_wr_ready;
    logic                  w_we;
    logic                  w_blank_last;
    logic [CH*COLS-1:0]    w_lit;
    logic                  w_row_any;

    // A write is refused while clearing or when a clear is being requested.
    assign w_wr_ready   = !rst && (r_state != ST_CLEAR) && !clear;
    assign wr_ready     = w_wr_ready;
    // Out-of-range addresses are handshaken but never reach the framebuffer.
    assign w_we         = wr_valid && w_wr_ready
                          && (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
    assign w_blank_last = (r_state == ST_BLANK) && (r_bcnt == c_blank_max);
    assign scan_row     = r_scan_row;

    // Per-pixel PWM compare on the displayed level; a row with nothing that
    // can light keeps its row driver off for the whole slot.
    always_comb begin
        logic [GRAY_BITS-1:0] w_lvl;
        w_lit     = '0;
        w_row_any = 1'b0;
        w_lvl     = '0;
        for (int c = 0; c < CH; c++) begin
            for (int j = 0; j < COLS; j++) begin
                w_lvl = r_shadow[j][c*GRAY_BITS +: GRAY_BITS];
                if (invert) begin
                    w_lvl = ~w_lvl;
                end
                w_lit[c*COLS + j] = (w_lvl > r_pcnt);
                if (w_lvl != '0) begin
                    w_row_any = 1'b1;
                end
            end
        end
    end

    // Scan sequencer: BLANK -> ACTIVE per row, with clear taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_BLANK;
            r_scan_row <= '0;
            r_bcnt     <= '0;
            r_ccnt     <= '0;
            r_pcnt     <= '0;
            r_presc    <= '0;
        end else if (clear) begin
            r_state    <= ST_CLEAR;
            r_ccnt     <= '0;
            r_bcnt     <= '0;
            r_pcnt     <= '0;
            r_presc    <= '0;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    if (r_bcnt == c_blank_max) begin
                        r_bcnt  <= '0;
                        r_pcnt  <= '0;
                        r_presc <= '0;
                        r_state <= ST_ACTIVE;
                    end else begin
                        r_bcnt <= r_bcnt + 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (r_presc == c_presc_max) begin
                        r_presc <= '0;
                        if (r_pcnt == c_pcnt_max) begin
                            r_pcnt     <= '0;
                            r_state    <= ST_BLANK;
                            r_scan_row <= (r_scan_row == c_row_max) ? '0 : r_scan_row + 1'b1;
                        end else begin
                            r_pcnt <= r_pcnt + 1'b1;
                        end
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (r_ccnt == c_row_max) begin
                        r_ccnt     <= '0;
                        r_bcnt     <= '0;
                        r_scan_row <= '0;
                        r_state    <= ST_BLANK;
                    end else begin
                        r_ccnt <= r_ccnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_BLANK;
                end
            endcase
        end
    end

    // Framebuffer: one row wiped per CLEAR cycle, host writes otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int j = 0; j < COLS; j++) begin
                    r_fb[r][j] <= '0;
                end
            end
        end else begin
            if (r_state == ST_CLEAR) begin
                for (int j = 0; j < COLS; j++) begin
                    r_fb[r_ccnt][j] <= '0;
                end
            end
            if (w_we) begin
                r_fb[wr_row][wr_col] <= wr_data;
            end
        end
    end

    // Shadow row latched on the last BLANK cycle, forwarding a same-cycle
    // write so the slot shows the freshest data without a tear mid-slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < COLS; j++) begin
                r_shadow[j] <= '0;
            end
        end else if (w_blank_last && !clear) begin
            for (int j = 0; j < COLS; j++) begin
                if (w_we && (wr_row == r_scan_row) && (wr_col == c_cw'(j))) begin
                    r_shadow[j] <= wr_data;
                end else begin
                    r_shadow[j] <= r_fb[r_scan_row][j];
                end
            end
        end
    end

    // Registered pin drive: row/column outputs lag the sequencer by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_n       <= '1;
            col         <= '0;
            frame_start <= 1'b0;
        end else begin
            row_n <= '1;
            if ((r_state == ST_ACTIVE) && w_row_any) begin
                row_n[r_scan_row] <= 1'b0;
            end
            col         <= (r_state == ST_ACTIVE) ? w_lit : '0;
            frame_start <= (r_state == ST_BLANK) && (r_scan_row == '0) && (r_bcnt == '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scan_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_matrix_scan_gen
//  Description : Directed self-checking bench for led_matrix_scan_gen at the
//                default parameters (8x8, 2 channels, 4 grey bits, 20-cycle
//                slot, 160-cycle frame).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_matrix_scan_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        invert;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_row;
    logic [2:0]  wr_col;
    logic [7:0]  wr_data;
    logic [7:0]  row_n;
    logic [15:0] col;
    logic [2:0]  scan_row;
    logic        frame_start;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int base     = 0;

    led_matrix_scan_gen dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .invert      (invert),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_data     (wr_data),
        .row_n       (row_n),
        .col         (col),
        .scan_row    (scan_row),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Cycle index: 0 is the cycle right after the last reset edge.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // PWM step shown on row r at cycle c, or -1 outside that row's window.
    function automatic int step(int c, int r);
        int p;
        p = c - base - 5;
        if (p < 0) return -1;
        p = p % 160;
        if ((p / 20 == r) && (p % 20 < 16)) return p % 20;
        return -1;
    endfunction

    // Expected row_n given the set of rows holding a displayable pixel.
    function automatic logic [7:0] exp_row_n(int c, logic [7:0] mask);
        int p;
        logic [7:0] one;
        one = 8'h01;
        p = c - base - 5;
        if (p < 0) return 8'hFF;
        p = p % 160;
        if ((p % 20 < 16) && mask[p / 20]) return ~(one << (p / 20));
        return 8'hFF;
    endfunction

    task automatic write_px(input logic [2:0] r, input logic [2:0] c, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_row   = r;
        wr_col   = c;
        wr_data  = d;
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL write_ready r%0d c%0d: got %b expected 1", r, c, wr_ready);
        end
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_pos(input int target);
        bit found;
        found = 0;
        for (int i = 0; i < 400; i++) begin
            if ((cyc - base) % 160 == target) begin
                found = 1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait_pos: frame position %0d not reached, got %0d", target, (cyc - base) % 160);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; invert = 1'b0; wr_valid = 1'b0;
        wr_row = '0; wr_col = '0; wr_data = '0;
        tick();
        tick();
        n_checks++;
        if (row_n !== 8'hFF) begin n_fail++; $display("FAIL reset_row_n: got %h expected ff", row_n); end
        n_checks++;
        if (col !== 16'h0) begin n_fail++; $display("FAIL reset_col: got %h expected 0000", col); end
        n_checks++;
        if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
        n_checks++;
        if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
        n_checks++;
        if (scan_row !== 3'd0) begin n_fail++; $display("FAIL reset_scan_row: got %0d expected 0", scan_row); end
        rst  = 1'b0;
        base = 0;
        #1;
        n_checks++;
        if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_wr_ready: got %b expected 1", wr_ready); end
    endtask

    task automatic test_idle_frames();
        int bad_row, bad_col, bad_rdy, fs_n, fs0, fs1;
        bad_row = 0; bad_col = 0; bad_rdy = 0; fs_n = 0; fs0 = -1; fs1 = -1;
        for (int i = 0; i < 320; i++) begin
            tick();
            if (row_n !== 8'hFF) bad_row++;
            if (col !== 16'h0) bad_col++;
            if (wr_ready !== 1'b1) bad_rdy++;
            if (frame_start === 1'b1) begin
                if (fs_n == 0) fs0 = cyc;
                if (fs_n == 1) fs1 = cyc;
                fs_n++;
            end
        end
        n_checks++;
        if (bad_row != 0) begin n_fail++; $display("FAIL idle_row_n: %0d cycles not ff, expected 0", bad_row); end
        n_checks++;
        if (bad_col != 0) begin n_fail++; $display("FAIL idle_col: %0d cycles nonzero, expected 0", bad_col); end
        n_checks++;
        if (bad_rdy != 0) begin n_fail++; $display("FAIL idle_wr_ready: %0d cycles low, expected 0", bad_rdy); end
        n_checks++;
        if (fs_n != 2) begin n_fail++; $display("FAIL idle_fs_count: got %0d expected 2", fs_n); end
        n_checks++;
        if (fs0 != 1) begin n_fail++; $display("FAIL idle_fs_first: got cycle %0d expected 1", fs0); end
        n_checks++;
        if (fs1 != 161) begin n_fail++; $display("FAIL idle_fs_second: got cycle %0d expected 161", fs1); end
    endtask

    task automatic test_single_pixel();
        int bad_row, c5, c13, stray, s;
        logic [15:0] allowed;
        bad_row = 0; c5 = 0; c13 = 0; stray = 0;
        write_px(3'd2, 3'd5, 8'h0F);
        for (int i = 0; i < 170; i++) begin
            tick();
            if (row_n !== exp_row_n(cyc, 8'h04)) bad_row++;
            s = step(cyc, 2);
            allowed = (s >= 0) ? 16'h0020 : 16'h0000;
            if ((s >= 0) && col[5]) c5++;
            if (col[13]) c13++;
            if ((col & ~allowed) != 16'h0) stray++;
        end
        n_checks++;
        if (bad_row != 0) begin n_fail++; $display("FAIL pixel_row_n: %0d bad cycles, expected 0", bad_row); end
        n_checks++;
        if (c5 != 15) begin n_fail++; $display("FAIL pixel_col5_count: got %0d expected 15", c5); end
        n_checks++;
        if (c13 != 0) begin n_fail++; $display("FAIL pixel_col13_count: got %0d expected 0", c13); end
        n_checks++;
        if (stray != 0) begin n_fail++; $display("FAIL pixel_stray_cols: got %0d expected 0", stray); end
    endtask

    task automatic test_invert();
        int c8, c9, c5, c8b, bad_row1, bad_row0;
        c8 = 0; c9 = 0; c5 = 0; c8b = 0; bad_row1 = 0; bad_row0 = 0;
        wait_pos(100);
        write_px(3'd0, 3'd0, 8'h40);
        invert = 1'b1;
        for (int i = 0; i < 160; i++) begin
            tick();
            if (row_n !== exp_row_n(cyc, 8'hFF)) bad_row1++;
            if ((step(cyc, 0) >= 0) && col[8]) c8++;
            if ((step(cyc, 0) >= 0) && col[9]) c9++;
            if ((step(cyc, 2) >= 0) && col[5]) c5++;
        end
        invert = 1'b0;
        for (int i = 0; i < 160; i++) begin
            tick();
            if (row_n !== exp_row_n(cyc, 8'h05)) bad_row0++;
            if ((step(cyc, 0) >= 0) && col[8]) c8b++;
        end
        n_checks++;
        if (c8 != 11) begin n_fail++; $display("FAIL invert_col8: got %0d expected 11", c8); end
        n_checks++;
        if (c9 != 15) begin n_fail++; $display("FAIL invert_col9_zero_level: got %0d expected 15", c9); end
        n_checks++;
        if (c5 != 0) begin n_fail++; $display("FAIL invert_col5_full_level: got %0d expected 0", c5); end
        n_checks++;
        if (bad_row1 != 0) begin n_fail++; $display("FAIL invert_row_n: %0d bad cycles, expected 0", bad_row1); end
        n_checks++;
        if (c8b != 4) begin n_fail++; $display("FAIL noinvert_col8: got %0d expected 4", c8b); end
        n_checks++;
        if (bad_row0 != 0) begin n_fail++; $display("FAIL noinvert_row_n: %0d bad cycles, expected 0", bad_row0); end
    endtask

    task automatic test_shadow();
        int t0, c_cur, c_nxt, rb_cur, rb_nxt;
        c_cur = 0; c_nxt = 0; rb_cur = 0; rb_nxt = 0;
        wait_pos(66);
        write_px(3'd3, 3'd2, 8'h08);
        t0 = cyc;
        for (int i = 0; i < 180; i++) begin
            tick();
            if (step(cyc, 3) >= 0) begin
                if (cyc - t0 < 50) begin
                    if (col[2]) c_cur++;
                    if (row_n !== 8'hFF) rb_cur++;
                end else begin
                    if (col[2]) c_nxt++;
                    if (row_n !== 8'hF7) rb_nxt++;
                end
            end
        end
        n_checks++;
        if (c_cur != 0) begin n_fail++; $display("FAIL shadow_current_slot: got %0d lit expected 0", c_cur); end
        n_checks++;
        if (rb_cur != 0) begin n_fail++; $display("FAIL shadow_current_row_n: %0d bad cycles, expected 0", rb_cur); end
        n_checks++;
        if (c_nxt != 8) begin n_fail++; $display("FAIL shadow_next_slot: got %0d lit expected 8", c_nxt); end
        n_checks++;
        if (rb_nxt != 0) begin n_fail++; $display("FAIL shadow_next_row_n: %0d bad cycles, expected 0", rb_nxt); end
    endtask

    task automatic test_clear();
        int t0, nz, blank_bad, fs_k, dark_bad, rbad, fs_n, fs_at;
        bit zrun;
        nz = 0; zrun = 1; blank_bad = 0; fs_k = -1;
        dark_bad = 0; rbad = 0; fs_n = 0; fs_at = -1;
        wait_pos(30);
        clear = 1'b1; wr_valid = 1'b1; wr_row = 3'd2; wr_col = 3'd5; wr_data = 8'hFF;
        #1;
        t0 = cyc;
        for (int k = 0; k < 12; k++) begin
            if (k == 1) begin
                clear = 1'b0; wr_valid = 1'b0;
                #1;
            end
            if (zrun && (wr_ready === 1'b0)) nz++;
            else zrun = 0;
            if ((k >= 2) && (k <= 9) && ((row_n !== 8'hFF) || (col !== 16'h0))) blank_bad++;
            if ((frame_start === 1'b1) && (fs_k < 0)) fs_k = k;
            tick();
        end
        base = t0 + 9;
        for (int i = 0; i < 170; i++) begin
            tick();
            if (col !== 16'h0) dark_bad++;
            if (row_n !== 8'hFF) rbad++;
            if (frame_start === 1'b1) begin fs_n++; fs_at = cyc; end
        end
        n_checks++;
        if (nz != 9) begin n_fail++; $display("FAIL clear_wr_ready_low: got %0d cycles expected 9", nz); end
        n_checks++;
        if (blank_bad != 0) begin n_fail++; $display("FAIL clear_outputs_blank: %0d bad cycles, expected 0", blank_bad); end
        n_checks++;
        if (fs_k != 10) begin n_fail++; $display("FAIL clear_frame_start: got offset %0d expected 10", fs_k); end
        n_checks++;
        if (dark_bad != 0) begin n_fail++; $display("FAIL clear_dark_col: %0d lit cycles, expected 0", dark_bad); end
        n_checks++;
        if (rbad != 0) begin n_fail++; $display("FAIL clear_dark_row_n: %0d bad cycles, expected 0", rbad); end
        n_checks++;
        if ((fs_n != 1) || (fs_at != base + 161)) begin
            n_fail++;
            $display("FAIL clear_next_frame: got %0d pulses last at %0d expected 1 at %0d", fs_n, fs_at, base + 161);
        end
    endtask

    task automatic test_reset_mid();
        int bad_col, bad_row, fs_n, fs0;
        bad_col = 0; bad_row = 0; fs_n = 0; fs0 = -1;
        write_px(3'd5, 3'd1, 8'hF0);
        wait_pos(110);
        n_checks++;
        if (row_n !== 8'hDF) begin n_fail++; $display("FAIL mid_row5_row_n: got %h expected df", row_n); end
        n_checks++;
        if (col !== 16'h0200) begin n_fail++; $display("FAIL mid_row5_col: got %h expected 0200", col); end
        n_checks++;
        if (scan_row !== 3'd5) begin n_fail++; $display("FAIL mid_row5_scan_row: got %0d expected 5", scan_row); end
        rst = 1'b1;
        tick();
        n_checks++;
        if (row_n !== 8'hFF) begin n_fail++; $display("FAIL rst_mid_row_n: got %h expected ff", row_n); end
        n_checks++;
        if (col !== 16'h0) begin n_fail++; $display("FAIL rst_mid_col: got %h expected 0000", col); end
        n_checks++;
        if (scan_row !== 3'd0) begin n_fail++; $display("FAIL rst_mid_scan_row: got %0d expected 0", scan_row); end
        rst  = 1'b0;
        base = 0;
        #1;
        for (int i = 0; i < 170; i++) begin
            tick();
            if (col !== 16'h0) bad_col++;
            if (row_n !== 8'hFF) bad_row++;
            if (frame_start === 1'b1) begin
                if (fs_n == 0) fs0 = cyc;
                fs_n++;
            end
        end
        n_checks++;
        if (bad_col != 0) begin n_fail++; $display("FAIL rst_mid_fb_zeroed: %0d lit cycles, expected 0", bad_col); end
        n_checks++;
        if (bad_row != 0) begin n_fail++; $display("FAIL rst_mid_row_idle: %0d bad cycles, expected 0", bad_row); end
        n_checks++;
        if ((fs_n != 2) || (fs0 != 1)) begin
            n_fail++;
            $display("FAIL rst_mid_frame_start: got %0d pulses first at %0d expected 2 first at 1", fs_n, fs0);
        end
    endtask

    initial begin
        test_reset();
        test_idle_frames();
        test_single_pixel();
        test_invert();
        test_shadow();
        test_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
